// File: rtl/axil_rr_arbiter.sv
// Round-robin N:1 AXI4-Lite arbiter, one transaction in flight at a time.
// Define AXIL_ARB_TIMEOUT_EN to add the slave response watchdog.
module axil_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_arvalid,
    output logic [NUM_MASTERS-1:0]            m_arready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_araddr,
    input  logic [NUM_MASTERS-1:0]            m_awvalid,
    output logic [NUM_MASTERS-1:0]            m_awready,
    input  logic [NUM_MASTERS*ADDR_W-1:0]     m_awaddr,
    input  logic [NUM_MASTERS-1:0]            m_wvalid,
    output logic [NUM_MASTERS-1:0]            m_wready,
    input  logic [NUM_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0]   m_wstrb,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    input  logic [NUM_MASTERS-1:0]            m_rready,
    output logic [NUM_MASTERS*DATA_W-1:0]     m_rdata,
    output logic [NUM_MASTERS*2-1:0]          m_rresp,
    output logic [NUM_MASTERS-1:0]            m_bvalid,
    input  logic [NUM_MASTERS-1:0]            m_bready,
    output logic [NUM_MASTERS*2-1:0]          m_bresp,
    output logic                              s_arvalid,
    input  logic                              s_arready,
    output logic [ADDR_W-1:0]                 s_araddr,
    output logic                              s_awvalid,
    input  logic                              s_awready,
    output logic [ADDR_W-1:0]                 s_awaddr,
    output logic                              s_wvalid,
    input  logic                              s_wready,
    output logic [DATA_W-1:0]                 s_wdata,
    output logic [DATA_W/8-1:0]               s_wstrb,
    input  logic                              s_rvalid,
    output logic                              s_rready,
    input  logic [DATA_W-1:0]                 s_rdata,
    input  logic [1:0]                        s_rresp,
    input  logic                              s_bvalid,
    output logic                              s_bready,
    input  logic [1:0]                        s_bresp,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_id,
    output logic                              busy
);
    localparam int IDW = $clog2(NUM_MASTERS);
    localparam int SW  = DATA_W / 8;

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || TIMEOUT_CYCLES < 1 || DATA_W % 8 != 0) begin : g_bad_cfg
        $error("axil_rr_arbiter: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_e;

    state_e                 state_q;
    logic [IDW-1:0]         grant_q, rr_ptr_q, pick, grant_inc;
    logic                   aw_done_q, w_done_q;
    logic [NUM_MASTERS-1:0] req, gnt_oh;
    logic                   found;
    logic                   sel_arv, sel_awv, sel_wv, sel_rr, sel_br;
    logic                   st_ra, st_rd, st_wr, st_wb;
    logic                   aw_fire, w_fire, rsp_rv, rsp_bv, m_r_fire, m_b_fire;
    logic                   timeout, drain;

    assign req       = m_arvalid | m_awvalid;
    assign gnt_oh    = NUM_MASTERS'(1) << grant_q;
    assign grant_inc = (grant_q == IDW'(NUM_MASTERS - 1)) ? '0 : grant_q + 1'b1;

    // First requester at or after rr_ptr, else first requester from 0 (wrap).
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i] && IDW'(i) >= rr_ptr_q) begin
                found = 1'b1;
                pick  = IDW'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (!found && req[i]) begin
                found = 1'b1;
                pick  = IDW'(i);
            end
        end
    end

    always_comb begin
        s_araddr = '0;
        s_awaddr = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        sel_arv  = 1'b0;
        sel_awv  = 1'b0;
        sel_wv   = 1'b0;
        sel_rr   = 1'b0;
        sel_br   = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == IDW'(i)) begin
                s_araddr = m_araddr[i*ADDR_W +: ADDR_W];
                s_awaddr = m_awaddr[i*ADDR_W +: ADDR_W];
                s_wdata  = m_wdata[i*DATA_W +: DATA_W];
                s_wstrb  = m_wstrb[i*SW +: SW];
                sel_arv  = m_arvalid[i];
                sel_awv  = m_awvalid[i];
                sel_wv   = m_wvalid[i];
                sel_rr   = m_rready[i];
                sel_br   = m_bready[i];
            end
        end
    end

    assign st_ra = (state_q == RD_ADDR);
    assign st_rd = (state_q == RD_DATA);
    assign st_wr = (state_q == WR_REQ);
    assign st_wb = (state_q == WR_RESP);

    assign s_arvalid = st_ra & sel_arv;
    assign s_awvalid = st_wr & ~aw_done_q & sel_awv;
    assign s_wvalid  = st_wr & ~w_done_q & sel_wv;
    assign aw_fire   = s_awvalid & s_awready;
    assign w_fire    = s_wvalid & s_wready;

    assign m_arready = gnt_oh & {NUM_MASTERS{st_ra & s_arready}};
    assign m_awready = gnt_oh & {NUM_MASTERS{st_wr & ~aw_done_q & s_awready}};
    assign m_wready  = gnt_oh & {NUM_MASTERS{st_wr & ~w_done_q & s_wready}};

    // A watchdog expiry substitutes a local SLVERR for the missing response.
    assign rsp_rv   = st_rd & (s_rvalid | timeout);
    assign rsp_bv   = st_wb & (s_bvalid | timeout);
    assign m_rvalid = gnt_oh & {NUM_MASTERS{rsp_rv}};
    assign m_bvalid = gnt_oh & {NUM_MASTERS{rsp_bv}};
    assign m_r_fire = rsp_rv & sel_rr;
    assign m_b_fire = rsp_bv & sel_br;
    assign s_rready = (st_rd & ~timeout & sel_rr) | drain;
    assign s_bready = (st_wb & ~timeout & sel_br) | drain;
    assign m_rdata  = {NUM_MASTERS{s_rdata}};
    assign m_rresp  = {NUM_MASTERS{(timeout ? 2'b10 : s_rresp)}};
    assign m_bresp  = {NUM_MASTERS{(timeout ? 2'b10 : s_bresp)}};

    assign grant_id = grant_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        grant_q <= pick;
                        state_q <= m_awvalid[pick] ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    if (s_arvalid && s_arready) state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (m_r_fire) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= grant_inc;
                    end
                end
                WR_REQ: begin
                    if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                        state_q   <= WR_RESP;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end else begin
                        if (aw_fire) aw_done_q <= 1'b1;
                        if (w_fire)  w_done_q  <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (m_b_fire) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= grant_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef AXIL_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);

    logic [WDW-1:0] wd_q;
    logic           drain_q;

    assign timeout = (wd_q == WDW'(TIMEOUT_CYCLES));
    assign drain   = drain_q;

    // Counter saturates at the limit so the error response holds until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            drain_q <= 1'b0;
        end else begin
            drain_q <= 1'b0;
            if (st_rd || st_wb) begin
                if (m_r_fire || m_b_fire) begin
                    wd_q    <= '0;
                    drain_q <= timeout;
                end else if (!timeout) begin
                    wd_q <= wd_q + 1'b1;
                end
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign drain   = 1'b0;
`endif

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// Directed bench for axil_rr_arbiter: two masters, one scripted slave.
module tb_axil_rr_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic rst;
    logic [N-1:0]    m_arvalid, m_arready, m_awvalid, m_awready;
    logic [N-1:0]    m_wvalid, m_wready, m_rvalid, m_rready, m_bvalid, m_bready;
    logic [N*AW-1:0] m_araddr, m_awaddr;
    logic [N*DW-1:0] m_wdata, m_rdata;
    logic [N*SW-1:0] m_wstrb;
    logic [N*2-1:0]  m_rresp, m_bresp;
    logic            s_arvalid, s_arready, s_awvalid, s_awready, s_wvalid, s_wready;
    logic            s_rvalid, s_rready, s_bvalid, s_bready;
    logic [AW-1:0]   s_araddr, s_awaddr;
    logic [DW-1:0]   s_wdata, s_rdata;
    logic [SW-1:0]   s_wstrb;
    logic [1:0]      s_rresp, s_bresp;
    logic [0:0]      grant_id;
    logic            busy;

    int nchk  = 0;
    int nfail = 0;
    int aw_beats = 0;
    int w_beats  = 0;
    int aw0, w0;

    axil_rr_arbiter #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (s_awvalid && s_awready) aw_beats <= aw_beats + 1;
        if (s_wvalid && s_wready)   w_beats  <= w_beats + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic rd_serve(input int m, input logic [31:0] addr, input logic [31:0] data);
        cyc();
        chk("rr_gid", 64'(grant_id), 64'(m));
        chk("rr_addr", 64'(s_araddr), 64'(addr));
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = data;
        #1;
        chk("rr_mrv", 64'(m_rvalid), 64'(1 << m));
        chk("rr_data", 64'(m_rdata[m*DW +: DW]), 64'(data));
        cyc();
        s_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        m_arvalid = '0; m_awvalid = '0; m_wvalid = '0; m_rready = '0; m_bready = '0;
        m_araddr = '0; m_awaddr = '0; m_wdata = '0; m_wstrb = '0;
        s_arready = 1'b0; s_awready = 1'b0; s_wready = 1'b0;
        s_rvalid = 1'b0; s_bvalid = 1'b0; s_rdata = '0; s_rresp = '0; s_bresp = '0;
        cyc();
        cyc();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_outs", 64'({s_arvalid, s_awvalid, s_wvalid, m_rvalid, m_bvalid}), 64'd0);
        rst = 1'b0;
        m_rready = '1;
        m_bready = '1;

        // single read from master 0
        m_arvalid = 2'b01;
        m_araddr[0 +: AW] = 32'h8000_0000;
        #1;
        chk("rd_no_comb", 64'(s_arvalid), 64'd0);
        cyc();
        chk("rd_sarv", 64'(s_arvalid), 64'd1);
        chk("rd_addr", 64'(s_araddr), 64'h8000_0000);
        chk("rd_busy", 64'(busy), 64'd1);
        s_arready = 1'b1;
        #1;
        chk("rd_marr", 64'(m_arready), 64'b01);
        cyc();
        m_arvalid = '0;
        s_arready = 1'b0;
        chk("rd_sarv_drop", 64'(s_arvalid), 64'd0);
        s_rvalid = 1'b1;
        s_rdata  = 32'hDEAD_BEEF;
        s_rresp  = 2'b00;
        #1;
        chk("rd_mrv", 64'(m_rvalid), 64'b01);
        chk("rd_data", 64'(m_rdata[0 +: DW]), 64'hDEAD_BEEF);
        chk("rd_resp", 64'(m_rresp[1:0]), 64'd0);
        chk("rd_srr", 64'(s_rready), 64'd1);
        cyc();
        s_rvalid = 1'b0;
        chk("rd_idle", 64'(busy), 64'd0);

        // fairness: both masters read continuously from rr_ptr=0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        m_araddr[0 +: AW]  = 32'h100;
        m_araddr[AW +: AW] = 32'h200;
        m_arvalid = 2'b11;
        rd_serve(0, 32'h100, 32'h1111_0000);
        rd_serve(1, 32'h200, 32'h2222_0001);
        rd_serve(0, 32'h100, 32'h3333_0000);
        m_arvalid = '0;

        // master 1 write, W accepted two cycles before AW
        aw0 = aw_beats;
        w0  = w_beats;
        m_awvalid = 2'b10;
        m_wvalid  = 2'b10;
        m_awaddr[AW +: AW] = 32'h10;
        m_wdata[DW +: DW]  = 32'h1234_5678;
        m_wstrb[SW +: SW]  = 4'hF;
        cyc();
        chk("wr_gid", 64'(grant_id), 64'd1);
        chk("wr_valids", 64'({s_awvalid, s_wvalid}), 64'b11);
        chk("wr_addr", 64'(s_awaddr), 64'h10);
        chk("wr_data", 64'(s_wdata), 64'h1234_5678);
        chk("wr_strb", 64'(s_wstrb), 64'hF);
        s_wready = 1'b1;
        #1;
        chk("wr_readies", 64'({m_wready, m_awready}), 64'b1000);
        cyc();
        m_wvalid = '0;
        s_wready = 1'b0;
        chk("wr_wdrop", 64'({s_awvalid, s_wvalid}), 64'b10);
        cyc();
        chk("wr_awhold", 64'({s_awvalid, s_wvalid}), 64'b10);
        s_awready = 1'b1;
        #1;
        chk("wr_mawr", 64'(m_awready), 64'b10);
        cyc();
        m_awvalid = '0;
        s_awready = 1'b0;
        chk("wr_resp_st", 64'({s_awvalid, s_wvalid, busy}), 64'b001);
        s_bvalid = 1'b1;
        s_bresp  = 2'b01;
        #1;
        chk("wr_mbv", 64'(m_bvalid), 64'b10);
        chk("wr_bresp", 64'(m_bresp[3:2]), 64'b01);
        chk("wr_sbr", 64'(s_bready), 64'd1);
        cyc();
        s_bvalid = 1'b0;
        chk("wr_idle", 64'(busy), 64'd0);
        chk("wr_awbeats", 64'(aw_beats - aw0), 64'd1);
        chk("wr_wbeats", 64'(w_beats - w0), 64'd1);

        // master 0 read and write together: write first, AW and W same cycle
        m_arvalid = 2'b01;
        m_awvalid = 2'b01;
        m_wvalid  = 2'b01;
        m_araddr[0 +: AW] = 32'h300;
        m_awaddr[0 +: AW] = 32'h400;
        m_wdata[0 +: DW]  = 32'hA5A5_A5A5;
        m_wstrb[0 +: SW]  = 4'h3;
        cyc();
        chk("wf_first", 64'({s_awvalid, s_wvalid, s_arvalid}), 64'b110);
        chk("wf_addr", 64'(s_awaddr), 64'h400);
        s_awready = 1'b1;
        s_wready  = 1'b1;
        #1;
        chk("wf_both", 64'({m_awready, m_wready}), 64'b0101);
        cyc();
        m_awvalid = '0;
        m_wvalid  = '0;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        chk("wf_resp_st", 64'({s_awvalid, s_wvalid, busy}), 64'b001);
        s_bvalid = 1'b1;
        s_bresp  = 2'b00;
        #1;
        chk("wf_mbv", 64'(m_bvalid), 64'b01);
        cyc();
        s_bvalid = 1'b0;
        chk("wf_idle", 64'(busy), 64'd0);
        cyc();
        chk("wf_rd", 64'({s_arvalid, s_awvalid}), 64'b10);
        chk("wf_raddr", 64'(s_araddr), 64'h300);
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        m_arvalid = '0;
        s_rvalid  = 1'b1;
        s_rdata   = 32'h0BAD_F00D;
        #1;
        chk("wf_rdata", 64'(m_rdata[0 +: DW]), 64'h0BAD_F00D);
        cyc();
        s_rvalid = 1'b0;

        // reset while master 1 sits in RD_DATA with a response pending
        m_arvalid = 2'b10;
        m_araddr[AW +: AW] = 32'h500;
        cyc();
        chk("mr_gid", 64'(grant_id), 64'd1);
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        m_arvalid = '0;
        s_rvalid  = 1'b1;
        #1;
        chk("mr_pre", 64'(m_rvalid), 64'b10);
        rst = 1'b1;
        cyc();
        chk("mr_busy", 64'(busy), 64'd0);
        chk("mr_gid0", 64'(grant_id), 64'd0);
        chk("mr_mouts", 64'({m_arready, m_awready, m_wready, m_rvalid, m_bvalid}), 64'd0);
        chk("mr_souts", 64'({s_arvalid, s_awvalid, s_wvalid}), 64'd0);
        rst = 1'b0;
        s_rvalid = 1'b0;

        // silent slave on a read from master 0
        m_arvalid = 2'b01;
        m_araddr[0 +: AW] = 32'h600;
        cyc();
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        m_arvalid = '0;
`ifdef AXIL_ARB_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            chk("to_wait", 64'(m_rvalid), 64'd0);
            cyc();
        end
        chk("to_mrv", 64'(m_rvalid), 64'b01);
        chk("to_resp", 64'(m_rresp[1:0]), 64'b10);
        chk("to_srr", 64'(s_rready), 64'd0);
        cyc();
        chk("to_idle", 64'(busy), 64'd0);
        chk("to_drain", 64'(s_rready), 64'd1);
        m_arvalid = 2'b10;
        m_araddr[AW +: AW] = 32'h700;
        cyc();
        chk("to_next", 64'({grant_id, s_arvalid}), 64'b11);
        chk("to_nodrain", 64'(s_rready), 64'd0);
        s_arready = 1'b1;
        cyc();
        s_arready = 1'b0;
        m_arvalid = '0;
        s_rvalid  = 1'b1;
        s_rdata   = 32'h7777_7777;
        s_rresp   = 2'b00;
        #1;
        chk("to_next_rv", 64'(m_rvalid), 64'b10);
        chk("to_next_resp", 64'(m_rresp[3:2]), 64'b00);
        cyc();
        s_rvalid = 1'b0;
`else
        for (int k = 0; k < 20; k++) begin
            chk("nw_wait", 64'({busy, m_rvalid}), 64'b100);
            cyc();
        end
        s_rvalid = 1'b1;
        s_rdata  = 32'h6666_6666;
        s_rresp  = 2'b00;
        #1;
        chk("nw_mrv", 64'(m_rvalid), 64'b01);
        chk("nw_resp", 64'(m_rresp[1:0]), 64'b00);
        cyc();
        s_rvalid = 1'b0;
        chk("nw_idle", 64'(busy), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule

// File: doc/axil_rr_arbiter.md
AXIL_RR_ARBITER -- requirements
Module: axil_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of AXI4-Lite masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width; strobe width is DATA_W/8.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 255, slave watchdog limit.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have master ports m_arvalid/m_arready/m_awvalid/m_awready/m_wvalid/m_wready/m_rvalid/m_rready/m_bvalid/m_bready, each NUM_MASTERS wide, bit i = master i.
REQ-008 SHALL have master ports m_araddr/m_awaddr (NUM_MASTERS*ADDR_W), m_wdata/m_rdata (NUM_MASTERS*DATA_W), m_wstrb (NUM_MASTERS*DATA_W/8), m_rresp/m_bresp (NUM_MASTERS*2), packed with master i at slice i.
REQ-009 SHALL have one slave port s_* carrying the same five channels at single-master widths.
REQ-010 SHALL have outputs grant_id (clog2(NUM_MASTERS)) and busy (1) as status.

Function
REQ-011 SHALL use FSM states IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
REQ-012 SHALL define request_i = m_arvalid[i] | m_awvalid[i].
REQ-013 In IDLE with any request, SHALL grant the first requesting master at or after rr_ptr (wrapping modulo NUM_MASTERS), register grant_id, and leave IDLE on the next edge.
REQ-014 If the granted master asserts m_awvalid, SHALL enter WR_REQ; otherwise SHALL enter RD_ADDR. Write beats read within one master.
REQ-015 SHALL add no combinational path from any master valid to the slave in IDLE: first slave valid appears one cycle after the request.
REQ-016 In RD_ADDR, SHALL forward the granted AR channel to s_ar*; on s_arvalid&s_arready SHALL go to RD_DATA.
REQ-017 In RD_DATA, SHALL route s_r* to the granted master only; on rvalid&rready SHALL go to IDLE.
REQ-018 In WR_REQ, SHALL forward AW and W concurrently, track aw_done/w_done separately, drop each channel's valid after its handshake, and go to WR_RESP when both are done (including in the same cycle).
REQ-019 In WR_RESP, SHALL route s_b* to the granted master; on bvalid&bready SHALL go to IDLE.
REQ-020 On return to IDLE, SHALL set rr_ptr = grant_id+1 with wrap (NUM_MASTERS-1 wraps to 0).
REQ-021 SHALL hold all ready/valid outputs to non-granted masters at 0; their response data is don't-care.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 A master deasserting valid before its handshake is a protocol violation; behaviour is then unspecified.
REQ-024 SHALL hold exactly one transaction outstanding at a time.

Reset
REQ-025 On rst, SHALL enter IDLE, set rr_ptr=0, grant_id=0, busy=0, clear aw_done/w_done/watchdog, and drive all valid/ready outputs to 0, including mid-transaction. A slave transaction in flight is abandoned.

Configuration
REQ-026 With macro AXIL_ARB_TIMEOUT_EN defined, SHALL count cycles spent in RD_DATA or WR_RESP. When the count reaches TIMEOUT_CYCLES, SHALL drive m_rvalid/m_bvalid to the granted master with resp=2'b10 (SLVERR) and hold it until that master handshakes. SHALL then return to IDLE and ignore any late slave response, holding s_rready/s_bready at 1 for one cycle to drain it.
REQ-027 Without AXIL_ARB_TIMEOUT_EN, SHALL wait indefinitely in RD_DATA and WR_RESP and SHALL instantiate no watchdog logic.

Verification
REQ-028 NUM_MASTERS=2; read from master 0 to 0x8000_0000, slave returns 0xDEADBEEF -> first s_arvalid one cycle after m_arvalid; master 0 receives rdata=0xDEADBEEF, rresp=0; master 1 sees no valid.
REQ-029 Masters 0 and 1 request reads in the same cycle three times, rr_ptr=0 -> grant order 0,1,0.
REQ-030 Master 1 write to addr 0x10, data 0x12345678, wstrb 0xF; slave accepts W two cycles before AW -> one W beat and one AW beat on the slave; bresp reaches master 1; state returns to IDLE.
REQ-031 Master 0 asserts arvalid and awvalid together -> write is serviced first, then the read is granted on a later arbitration.
REQ-032 rst asserted during RD_DATA -> next cycle: IDLE, busy=0, grant_id=0, all m_* valid/ready outputs 0.
REQ-033 With AXIL_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never responds to a read -> master receives rresp=2'b10 after 16 cycles in RD_DATA; next request is granted normally.
